udma_i2c_cmd_seq: RTL and testbench
===================================

Name: udma_i2c_cmd_seq

Overview:
Command sequencer between the uDMA I2C TX/RX byte streams and the bit-level I2C engine. It fetches command bytes, and argument bytes where an opcode takes them, from the TX stream. Each decoded command goes to the bit engine through a valid/ready handshake, and read data returns on the RX stream. It drives the status signals the I2C register interface samples: busy, arbitration lost and nack. It also takes the soft reset that interface produces.

Parameters:
DIV_WIDTH, 16, width of SCL clock divider output
DIV_RESET, 16'h0100, clk_div_o value after reset / cfg_do_rst_i

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset; synchronous and active-low
cfg_do_rst_i  in  1  soft reset from register interface, level, same effect as rstn_i
tx_data_i  in  8  command/argument byte from uDMA TX channel
tx_valid_i  in  1  TX byte valid
tx_ready_o  out  1  TX byte accepted when valid&ready
rx_data_o  out  8  read byte to uDMA RX channel
rx_valid_o  out  1  RX byte valid
rx_ready_i  in  1  RX byte consumed
core_cmd_o  out  3  0 START, 1 STOP, 2 READ, 3 WRITE, 4 WAIT
core_data_o  out  8  write byte or wait count
core_ack_o  out  1  ACK bit to drive after READ (0 = ACK, 1 = NACK)
core_valid_o  out  1  command valid to bit engine
core_ready_i  in  1  bit engine accepts command
core_done_i  in  1  1-cycle pulse: accepted command finished
core_rdata_i  in  8  read byte, valid with core_done_i
core_nack_i  in  1  slave NACK on WRITE, valid with core_done_i
core_al_i  in  1  arbitration lost, any cycle
clk_div_o  out  DIV_WIDTH  SCL divider to bit engine
status_busy_o  out  1  sequencer not idle
status_al_o  out  1  1-cycle pulse on arbitration loss
nack_o  out  1  1-cycle pulse on slave NACK

Behaviour:
- Opcode is tx_data_i[7:4]; bits [3:0] are ignored.
- Opcodes:
  - 0x0 START
  - 0x2 STOP
  - 0x4 RD_ACK
  - 0x6 RD_NACK
  - 0x8 WR: 1 argument byte, the data
  - 0xA WAIT: 1 argument byte, the count of SCL periods
  - 0xC RPT: 1 argument byte, N
  - 0xE CFG: 2 argument bytes, divider MSB first, zero-extended/truncated to DIV_WIDTH
  - Any other opcode: consumed and ignored.
- FSM states: IDLE, ARG1, ARG2, ISSUE, WAIT_DONE, PUSH_RX, ABORT.
  - IDLE: tx_ready_o=1. Opcode with arguments → ARG1. START/STOP/RD_* → ISSUE. Ignored opcodes stay in IDLE.
  - ARG1/ARG2: tx_ready_o=1 until the arguments are captured. CFG updates clk_div_o the cycle after its 2nd byte, then → IDLE (no core command). RPT loads the repeat counter, then → IDLE. WR/WAIT → ISSUE.
  - ISSUE: core_valid_o=1 with stable cmd/data/ack until core_ready_i → WAIT_DONE.
  - WAIT_DONE: on core_done_i:
    - READ → PUSH_RX, with rx_data_o=core_rdata_i.
    - WRITE with core_nack_i → nack_o pulse next cycle; the sequence continues.
    - Then, if the repeat count is >1: decrement and reissue. WR refetches a new data byte (→ ARG1); other commands → ISSUE.
    - Otherwise → IDLE.
  - PUSH_RX: rx_valid_o=1 held until rx_ready_i, then follows the same repeat/IDLE rule.
- Repeat: N=0 or N=1 → next command executes once. RPT followed by START/STOP/CFG/RPT → the counter is cleared and the command executes once.
- Latency: a no-argument opcode accepted in cycle t raises core_valid_o in t+1. The final argument byte accepted in t raises core_valid_o in t+1.
- core_al_i in any state:
  - status_al_o pulses next cycle.
  - → ABORT: core_valid_o=0, rx_valid_o=0, repeat counter cleared.
  - ABORT: tx_ready_o=1 and all bytes are discarded until rstn_i low or cfg_do_rst_i high.
  - core_al_i has priority over a simultaneous core_done_i; its read data is dropped.
- status_busy_o=1 in every state except IDLE, and except while an RPT is pending.
- Reset (rstn_i low at clk edge, or cfg_do_rst_i high):
  - → IDLE.
  - All outputs 0 except clk_div_o=DIV_RESET and tx_ready_o=1 (IDLE).
  - Repeat counter cleared; any in-flight command abandoned.
- A simultaneous cfg_do_rst_i and core_al_i → reset wins.

Optional Feature:
- Macro I2C_CMD_RPT_EN.
- Defined: RPT opcode is supported as above.
- Undefined: 0xC is treated as an ignored opcode. Its following byte is decoded as a new opcode. No repeat counter is synthesized.

Test Plan:
- TX 0x00,0x80,0xA0,0x20 with core accepting immediately → START; WRITE data 0xA0; STOP. core_valid_o one cycle after each byte. status_busy_o low at the end.
- TX 0xC0,0x03,0x40, core returns 0x11,0x22,0x33 → three READs with core_ack_o=0. RX stream 0x11,0x22,0x33. rx_ready_i held low 5 cycles on the 2nd byte → no 3rd READ issued until it is consumed.
- TX 0xE0,0x12,0x34 → clk_div_o=16'h1234. No core_valid_o.
- WR 0x55 with core_done_i & core_nack_i → nack_o single-cycle pulse. A following STOP is still issued.
- core_al_i during WAIT_DONE of a WRITE, then TX 0x20 → status_al_o pulse. 0x20 discarded and no core command. After cfg_do_rst_i: IDLE, clk_div_o=16'h0100.
- Build without I2C_CMD_RPT_EN, TX 0xC0,0x20 → 0xC0 ignored; 0x20 executes a STOP.

Source files
------------

// File: rtl/udma_i2c_cmd_seq.sv
// uDMA I2C command sequencer: fetches opcodes/arguments from the TX byte stream and drives the
// bit engine, returning read bytes on RX. Define I2C_CMD_RPT_EN to enable the RPT opcode.
module udma_i2c_cmd_seq #(
  parameter int unsigned          DIV_WIDTH = 16,
  parameter logic [DIV_WIDTH-1:0] DIV_RESET = 16'h0100
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 cfg_do_rst_i,
  input  logic [7:0]           tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [7:0]           rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic [2:0]           core_cmd_o,
  output logic [7:0]           core_data_o,
  output logic                 core_ack_o,
  output logic                 core_valid_o,
  input  logic                 core_ready_i,
  input  logic                 core_done_i,
  input  logic [7:0]           core_rdata_i,
  input  logic                 core_nack_i,
  input  logic                 core_al_i,
  output logic [DIV_WIDTH-1:0] clk_div_o,
  output logic                 status_busy_o,
  output logic                 status_al_o,
  output logic                 nack_o
);

  typedef enum logic [2:0] {
    StIdle, StArg1, StArg2, StIssue, StWaitDone, StPushRx, StAbort
  } state_e;

  localparam logic [3:0] OpStart  = 4'h0;
  localparam logic [3:0] OpStop   = 4'h2;
  localparam logic [3:0] OpRdAck  = 4'h4;
  localparam logic [3:0] OpRdNack = 4'h6;
  localparam logic [3:0] OpWr     = 4'h8;
  localparam logic [3:0] OpWait   = 4'hA;
  localparam logic [3:0] OpRpt    = 4'hC;
  localparam logic [3:0] OpCfg    = 4'hE;

  localparam logic [2:0] CmdStart = 3'd0;
  localparam logic [2:0] CmdStop  = 3'd1;
  localparam logic [2:0] CmdRead  = 3'd2;
  localparam logic [2:0] CmdWrite = 3'd3;
  localparam logic [2:0] CmdWait  = 3'd4;

  state_e               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [2:0]           cmd_q, cmd_d;
  logic [7:0]           data_q, data_d;
  logic                 ack_q, ack_d;
  logic [7:0]           hi_q, hi_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 al_q, al_d;
  logic                 nack_q, nack_d;
  logic                 rpt_more;
  state_e               rpt_next;

`ifdef I2C_CMD_RPT_EN
  logic [7:0] rpt_q, rpt_d;
  assign rpt_more = (rpt_q > 8'd1);
`else
  assign rpt_more = 1'b0;
`endif

  // A repeated WR must fetch a fresh data byte; other commands reissue as-is.
  assign rpt_next = !rpt_more ? StIdle : ((cmd_q == CmdWrite) ? StArg1 : StIssue);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    ack_d        = ack_q;
    hi_d         = hi_q;
    div_d        = div_q;
    rdata_d      = rdata_q;
    al_d         = 1'b0;
    nack_d       = 1'b0;
`ifdef I2C_CMD_RPT_EN
    rpt_d        = rpt_q;
`endif
    tx_ready_o   = 1'b0;
    core_valid_o = 1'b0;
    rx_valid_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_ready_o = 1'b1;
        if (tx_valid_i) begin
          op_d = tx_data_i[7:4];
          case (tx_data_i[7:4])
            OpStart, OpStop: begin
              cmd_d   = (tx_data_i[7:4] == OpStart) ? CmdStart : CmdStop;
              state_d = StIssue;
`ifdef I2C_CMD_RPT_EN
              rpt_d   = 8'd0;
`endif
            end
            OpRdAck, OpRdNack: begin
              cmd_d   = CmdRead;
              ack_d   = (tx_data_i[7:4] == OpRdNack);
              state_d = StIssue;
            end
            OpWr: begin
              cmd_d   = CmdWrite;
              state_d = StArg1;
            end
            OpWait: begin
              cmd_d   = CmdWait;
              state_d = StArg1;
            end
`ifdef I2C_CMD_RPT_EN
            OpRpt: state_d = StArg1;
`endif
            OpCfg: begin
              state_d = StArg1;
`ifdef I2C_CMD_RPT_EN
              rpt_d   = 8'd0;
`endif
            end
            default: ;
          endcase
        end
      end
      StArg1: begin
        tx_ready_o = 1'b1;
        if (tx_valid_i) begin
          case (op_q)
            OpCfg: begin
              hi_d    = tx_data_i;
              state_d = StArg2;
            end
`ifdef I2C_CMD_RPT_EN
            OpRpt: begin
              rpt_d   = tx_data_i;
              state_d = StIdle;
            end
`endif
            default: begin
              data_d  = tx_data_i;
              state_d = StIssue;
            end
          endcase
        end
      end
      StArg2: begin
        tx_ready_o = 1'b1;
        if (tx_valid_i) begin
          div_d   = DIV_WIDTH'({hi_q, tx_data_i});
          state_d = StIdle;
        end
      end
      StIssue: begin
        core_valid_o = 1'b1;
        if (core_ready_i) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (core_done_i) begin
          if (cmd_q == CmdRead) begin
            rdata_d = core_rdata_i;
            state_d = StPushRx;
          end else begin
            nack_d  = (cmd_q == CmdWrite) && core_nack_i;
            state_d = rpt_next;
`ifdef I2C_CMD_RPT_EN
            rpt_d   = rpt_more ? rpt_q - 8'd1 : 8'd0;
`endif
          end
        end
      end
      StPushRx: begin
        rx_valid_o = 1'b1;
        if (rx_ready_i) begin
          state_d = rpt_next;
`ifdef I2C_CMD_RPT_EN
          rpt_d   = rpt_more ? rpt_q - 8'd1 : 8'd0;
`endif
        end
      end
      StAbort: tx_ready_o = 1'b1;
      default: state_d = StIdle;
    endcase

    // Arbitration loss overrides everything, including a coincident completion.
    if (core_al_i) begin
      al_d    = 1'b1;
      nack_d  = 1'b0;
      rdata_d = rdata_q;
      state_d = StAbort;
`ifdef I2C_CMD_RPT_EN
      rpt_d   = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || cfg_do_rst_i) begin
      state_q <= StIdle;
      op_q    <= 4'h0;
      cmd_q   <= 3'd0;
      data_q  <= 8'h00;
      ack_q   <= 1'b0;
      hi_q    <= 8'h00;
      div_q   <= DIV_RESET;
      rdata_q <= 8'h00;
      al_q    <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      hi_q    <= hi_d;
      div_q   <= div_d;
      rdata_q <= rdata_d;
      al_q    <= al_d;
      nack_q  <= nack_d;
    end
  end

`ifdef I2C_CMD_RPT_EN
  always_ff @(posedge clk_i) begin
    if (!rstn_i || cfg_do_rst_i) rpt_q <= 8'd0;
    else                         rpt_q <= rpt_d;
  end
`endif

  assign core_cmd_o    = cmd_q;
  assign core_data_o   = data_q;
  assign core_ack_o    = ack_q;
  assign rx_data_o     = rdata_q;
  assign clk_div_o     = div_q;
  assign status_busy_o = (state_q != StIdle);
  assign status_al_o   = al_q;
  assign nack_o        = nack_q;

endmodule

// File: tb/tb_udma_i2c_cmd_seq.sv
// Directed bench for udma_i2c_cmd_seq: a cycle table for START/WR/STOP, then hand sequences
// for repeat (or its absence), CFG, slave NACK, arbitration loss and soft reset.
module tb_udma_i2c_cmd_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cfg_do_rst = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready_o;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready = 1'b0;
  logic [2:0]  core_cmd_o;
  logic [7:0]  core_data_o;
  logic        core_ack_o;
  logic        core_valid_o;
  logic        core_ready = 1'b0;
  logic        core_done = 1'b0;
  logic [7:0]  core_rdata = 8'h00;
  logic        core_nack = 1'b0;
  logic        core_al = 1'b0;
  logic [15:0] clk_div_o;
  logic        status_busy_o;
  logic        status_al_o;
  logic        nack_o;

  int n_checks = 0;
  int n_pass = 0;

  udma_i2c_cmd_seq #(.DIV_WIDTH(16), .DIV_RESET(16'h0100)) dut (
    .clk_i(clk), .rstn_i(rstn), .cfg_do_rst_i(cfg_do_rst),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready),
    .core_cmd_o(core_cmd_o), .core_data_o(core_data_o), .core_ack_o(core_ack_o),
    .core_valid_o(core_valid_o), .core_ready_i(core_ready), .core_done_i(core_done),
    .core_rdata_i(core_rdata), .core_nack_i(core_nack), .core_al_i(core_al),
    .clk_div_o(clk_div_o), .status_busy_o(status_busy_o), .status_al_o(status_al_o),
    .nack_o(nack_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  typedef struct packed {
    logic       tx_v;
    logic [7:0] tx_d;
    logic       c_rdy;
    logic       c_done;
    logic       e_tr;
    logic       e_cv;
    logic [2:0] e_cmd;
    logic [7:0] e_data;
    logic       e_busy;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    $display("FAIL %s: got timeout, expected handshake", nm);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    while (!tx_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready_o) timeout("tx_accept");
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic serve(input string nm, input logic [2:0] cmd, input logic [7:0] data,
                       input logic chk_data, input logic [7:0] rdata, input logic nack);
    int n = 0;
    @(negedge clk);
    while (!core_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!core_valid_o) begin
      timeout({nm, "_valid"});
      return;
    end
    check({nm, "_cmd"}, 32'(core_cmd_o), 32'(cmd));
    if (chk_data) check({nm, "_data"}, 32'(core_data_o), 32'(data));
    if (cmd == 3'd2) check({nm, "_ack"}, 32'(core_ack_o), 32'(0));
    core_ready = 1'b1;
    @(negedge clk);
    core_ready = 1'b0;
    core_done  = 1'b1;
    core_rdata = rdata;
    core_nack  = nack;
    @(negedge clk);
    core_done = 1'b0;
    core_nack = 1'b0;
    if (nack) begin
      check({nm, "_nack_hi"}, 32'(nack_o), 32'(1));
      @(negedge clk);
      check({nm, "_nack_lo"}, 32'(nack_o), 32'(0));
    end
  endtask

  task automatic rx_pop(input logic [7:0] exp, input int hold);
    int n = 0;
    while (!rx_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_valid_o) begin
      timeout("rx_valid");
      return;
    end
    check("rx_data", 32'(rx_data_o), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rx_hold_no_reissue", 32'({core_valid_o, rx_valid_o}), 32'(2'b01));
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    //               tx_v tx_d  rdy done | tr cv cmd data busy
    vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1};
    vecs[3]  = '{1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 8'hA0, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1};
    vecs[7]  = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    check("rst_tx_ready", 32'(tx_ready_o), 32'(1));
    check("rst_clk_div", 32'(clk_div_o), 32'h0100);
    check("rst_quiet", 32'({core_valid_o, rx_valid_o, status_busy_o, status_al_o, nack_o}),
          32'(0));
    check("rst_regs", 32'({core_cmd_o, core_data_o, core_ack_o, rx_data_o}), 32'(0));

    // START; WR 0xA0; STOP with an immediately ready core.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      tx_valid   = vecs[i].tx_v;
      tx_data    = vecs[i].tx_d;
      core_ready = vecs[i].c_rdy;
      core_done  = vecs[i].c_done;
      check($sformatf("vec%0d_ctl", i),
            32'({tx_ready_o, core_valid_o, status_busy_o, nack_o, status_al_o}),
            32'({vecs[i].e_tr, vecs[i].e_cv, vecs[i].e_busy, 2'b00}));
      if (vecs[i].e_cv) check($sformatf("vec%0d_cmd", i), 32'(core_cmd_o), 32'(vecs[i].e_cmd));
      if (vecs[i].e_cv && vecs[i].e_cmd == 3'd3)
        check($sformatf("vec%0d_data", i), 32'(core_data_o), 32'(vecs[i].e_data));
    end
    @(negedge clk);
    tx_valid   = 1'b0;
    core_ready = 1'b0;
    core_done  = 1'b0;

`ifdef I2C_CMD_RPT_EN
    // RPT 3 x RD_ACK with back-pressure on the second RX byte.
    send_byte(8'hC0);
    send_byte(8'h03);
    send_byte(8'h40);
    serve("rpt_rd1", 3'd2, 8'h00, 1'b0, 8'h11, 1'b0);
    rx_pop(8'h11, 0);
    serve("rpt_rd2", 3'd2, 8'h00, 1'b0, 8'h22, 1'b0);
    rx_pop(8'h22, 5);
    serve("rpt_rd3", 3'd2, 8'h00, 1'b0, 8'h33, 1'b0);
    rx_pop(8'h33, 0);
    @(negedge clk);
    check("rpt_done_idle", 32'({status_busy_o, core_valid_o}), 32'(0));
`else
    // Without repeat support 0xC0 is dropped and the next byte is a fresh opcode.
    send_byte(8'hC0);
    @(negedge clk);
    check("norpt_c0_idle", 32'({status_busy_o, core_valid_o}), 32'(0));
    send_byte(8'h20);
    serve("norpt_stop", 3'd1, 8'h00, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("norpt_stop_idle", 32'(status_busy_o), 32'(0));
`endif

    // CFG sets the divider and issues nothing to the core.
    send_byte(8'hE0);
    send_byte(8'h12);
    send_byte(8'h34);
    @(negedge clk);
    check("cfg_div", 32'(clk_div_o), 32'h1234);
    check("cfg_no_core", 32'({core_valid_o, status_busy_o}), 32'(0));

    // WR 0x55 NACKed by the slave, then a STOP still goes out.
    send_byte(8'h80);
    send_byte(8'h55);
    serve("nack_wr", 3'd3, 8'h55, 1'b1, 8'h00, 1'b1);
    send_byte(8'h20);
    serve("nack_stop", 3'd1, 8'h00, 1'b0, 8'h00, 1'b0);

    // Arbitration loss while a WRITE is in flight.
    send_byte(8'h80);
    send_byte(8'hAA);
    begin
      int n = 0;
      @(negedge clk);
      while (!core_valid_o && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!core_valid_o) timeout("al_valid");
    end
    core_ready = 1'b1;
    @(negedge clk);
    core_ready = 1'b0;
    core_al    = 1'b1;
    @(negedge clk);
    core_al = 1'b0;
    check("al_pulse_hi", 32'({status_al_o, status_busy_o, core_valid_o}), 32'(3'b110));
    @(negedge clk);
    check("al_pulse_lo", 32'(status_al_o), 32'(0));
    check("al_abort_tx_ready", 32'(tx_ready_o), 32'(1));
    send_byte(8'h20);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("al_discard", 32'({core_valid_o, rx_valid_o, status_busy_o}), 32'(3'b001));
    end
    cfg_do_rst = 1'b1;
    @(negedge clk);
    cfg_do_rst = 1'b0;
    check("softrst_idle", 32'({status_busy_o, tx_ready_o, core_valid_o}), 32'(3'b010));
    check("softrst_div", 32'(clk_div_o), 32'h0100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
